fpga_clk_cfg_ctrl: RTL
======================

FPGA_CLK_CFG_CTRL -- requirements
Module: fpga_clk_cfg_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning the number of independent config channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 8, meaning the width of each channel's divider field (2..16).
REQ-003 SHALL have parameter ID_BASE, default 32'h0001_0000, meaning the ID word base; channel c reads ID_BASE + (c<<16).
REQ-004 ref_clk_i  in  1  the single clock; all logic is rising-edge.
REQ-005 rst_glob_i  in  1  asynchronous, active-high reset.
REQ-006 cfg_req_i  in  NUM_CH  per-channel request.
REQ-007 cfg_wrn_i  in  NUM_CH  per-channel direction: 1 = read, 0 = write.
REQ-008 cfg_add_i  in  NUM_CH x 5  per-channel register address.
REQ-009 cfg_data_i  in  NUM_CH x 32  per-channel write data.
REQ-010 cfg_ack_o  out  NUM_CH  per-channel acknowledge.
REQ-011 cfg_r_data_o  out  NUM_CH x 32  per-channel read data.
REQ-012 lock_i  in  NUM_CH  raw PLL/MMCM lock, asynchronous.
REQ-013 cfg_lock_o  out  NUM_CH  synchronised lock.
REQ-014 clk_en_o  out  NUM_CH  per-channel divided clock-enable pulse.

Function
REQ-015 Each channel SHALL run its own FSM with states IDLE, ACK and HOLD.
- IDLE: cfg_req_i high goes to ACK.
- ACK: lasts exactly one cycle, then goes to HOLD.
- HOLD: returns to IDLE when cfg_req_i is low.
REQ-016 cfg_ack_o SHALL be high only in ACK, i.e. one cycle after the req is sampled, and for one cycle.
REQ-017 A held req SHALL NOT be re-acknowledged; a new transaction needs req to go low first.
REQ-018 The address and write data SHALL be captured in the IDLE->ACK cycle; a write takes effect on the ack cycle.
REQ-019 Read data SHALL be registered, valid while ack is high, and hold its value until the next read ack.
REQ-020 The register map SHALL be:
- 0 DIV: rw, [DIV_W-1:0].
- 1 CTRL: rw, bit0 = enable.
- 2 STATUS: bit0 = lock (ro), bit1 = lock_lost (sticky, write-1-clear).
- 3 ID: ro, ID_BASE + (c<<16).
- 4 LOSS_CNT: ro, see REQ-029.
- Other addresses SHALL read 0 and ignore writes.
REQ-021 DIV bits above DIV_W SHALL read 0.
REQ-022 Divider: when enable is 1, a counter SHALL count 0..DIV-1 and clk_en_o SHALL pulse for one cycle when the counter is 0.
- DIV = 0 or 1 SHALL give clk_en_o constantly high.
REQ-023 When enable is 0, the counter SHALL hold at 0 and clk_en_o SHALL be 0.
REQ-024 A write to DIV or CTRL SHALL restart the counter at 0, so the first pulse comes the cycle after the write.
REQ-025 lock_i SHALL pass through a 2-flop synchroniser; cfg_lock_o is the second flop.
REQ-026 A 1->0 transition of the synchronised lock SHALL set lock_lost.
- If a set and a W1C land in the same cycle, the set SHALL win.
REQ-027 Channels SHALL be fully independent; simultaneous requests on all channels SHALL all be acked in the same cycle.

Reset
REQ-028 While rst_glob_i is high, the following SHALL hold:
- every FSM is in IDLE;
- cfg_ack_o, cfg_r_data_o, clk_en_o and cfg_lock_o are 0;
- sync flops, DIV, CTRL, lock_lost and LOSS_CNT are 0.
- Reset mid-transaction SHALL abort it with no ack.

Configuration
REQ-029 With macro CLK_CFG_LOSS_CNT_EN defined, each channel SHALL include an 8-bit saturating counter of lock-loss events, readable at address 4 and cleared by any write to address 4.
- Without the macro, address 4 SHALL read 0 and no counter SHALL be instantiated.

Structure
REQ-030 Package clk_cfg_pkg SHALL hold the register-address localparams, the FSM state enum and the STATUS bit indices.
REQ-031 The per-channel logic SHALL live in sub-module clk_cfg_channel, generated NUM_CH times.

Verification
REQ-032 Write DIV=4 then CTRL=1 on ch0 -> ack 1 cycle after each req; clk_en_o[0] pulses every 4 cycles, starting the cycle after the CTRL ack.
REQ-033 Read address 3 on ch2 (defaults) -> r_data 32'h0003_0000 with ack; hold req 5 cycles -> only one ack.
REQ-034 Drop lock_i[1] for 10 cycles -> cfg_lock_o[1] falls 2 cycles later.
- STATUS reads 2'b10 while lock is low.
- After relock, write STATUS=2 -> STATUS reads 1.
- With CLK_CFG_LOSS_CNT_EN, LOSS_CNT = 1; 300 losses -> 255.
REQ-035 Assert req on all 3 channels in one cycle with different addresses -> three simultaneous acks, each with correct data; read address 9 -> 0.
REQ-036 Assert rst_glob_i during ACK with DIV=3 and enable=1 -> ack drops immediately; clk_en_o = 0; DIV reads 0 after reset.

Source files
------------

// File: rtl/clk_cfg_pkg.sv
// Shared register map, status bit positions and channel FSM encoding for fpga_clk_cfg_ctrl.
package clk_cfg_pkg;

  localparam logic [4:0] ADDR_DIV      = 5'd0;
  localparam logic [4:0] ADDR_CTRL     = 5'd1;
  localparam logic [4:0] ADDR_STATUS   = 5'd2;
  localparam logic [4:0] ADDR_ID       = 5'd3;
  localparam logic [4:0] ADDR_LOSS_CNT = 5'd4;

  localparam int CTRL_EN_BIT     = 0;
  localparam int STATUS_LOCK_BIT = 0;
  localparam int STATUS_LOST_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/clk_cfg_channel.sv
// One config channel: req/ack handshake, DIV/CTRL/STATUS registers, lock synchroniser, divider.
// Optional lock-loss counter at address 4 is built only when CLK_CFG_LOSS_CNT_EN is defined.
module clk_cfg_channel
  import clk_cfg_pkg::*;
#(
  parameter int          DIV_W   = 8,
  parameter logic [31:0] ID_WORD = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wrn,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        lock_raw,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        lock_sync,
  output logic        clk_en
);

  cfg_state_t       state_reg, state_next;
  logic [4:0]       addr_reg;
  logic [DIV_W-1:0] wdata_reg;
  logic             is_wr_reg;
  logic [31:0]      r_data_reg, read_word, loss_word;
  logic [DIV_W-1:0] div_reg, cnt_reg;
  logic             en_reg, sync1_reg, sync2_reg, lost_reg;
  logic             capture, wr_stb, wr_div, wr_ctrl, wr_status, loss_evt;
  logic             unused_wdata_bits;

  // Only the low DIV_W bits of write data ever reach a register.
  assign unused_wdata_bits = ^wdata[31:DIV_W];

  always_comb begin
    state_next = state_reg;
    ack        = 1'b0;
    case (state_reg)
      ST_IDLE: if (req) state_next = ST_ACK;
      ST_ACK: begin
        ack        = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: if (!req) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign capture   = (state_reg == ST_IDLE) && req;
  assign wr_stb    = (state_reg == ST_ACK) && is_wr_reg;
  assign wr_div    = wr_stb && (addr_reg == ADDR_DIV);
  assign wr_ctrl   = wr_stb && (addr_reg == ADDR_CTRL);
  assign wr_status = wr_stb && (addr_reg == ADDR_STATUS);
  // Falling edge of the synchronised lock, seen one stage early so lost sets as cfg_lock drops.
  assign loss_evt  = sync2_reg & ~sync1_reg;

  always_comb begin
    read_word = '0;
    case (addr)
      ADDR_DIV:  read_word[DIV_W-1:0] = div_reg;
      ADDR_CTRL: read_word[CTRL_EN_BIT] = en_reg;
      ADDR_STATUS: begin
        read_word[STATUS_LOCK_BIT] = sync2_reg;
        read_word[STATUS_LOST_BIT] = lost_reg;
      end
      ADDR_ID:       read_word = ID_WORD;
      ADDR_LOSS_CNT: read_word = loss_word;
      default:       read_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      is_wr_reg  <= 1'b0;
      r_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        addr_reg  <= addr;
        wdata_reg <= wdata[DIV_W-1:0];
        is_wr_reg <= ~wrn;
        if (wrn) r_data_reg <= read_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg   <= '0;
      en_reg    <= 1'b0;
      lost_reg  <= 1'b0;
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= lock_raw;
      sync2_reg <= sync1_reg;
      if (wr_div)  div_reg <= wdata_reg;
      if (wr_ctrl) en_reg  <= wdata_reg[CTRL_EN_BIT];
      if (loss_evt)
        lost_reg <= 1'b1;
      else if (wr_status && wdata_reg[STATUS_LOST_BIT])
        lost_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else if (wr_div || wr_ctrl || !en_reg || (div_reg <= DIV_W'(1)))
      cnt_reg <= '0;
    else if (cnt_reg == div_reg - DIV_W'(1))
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + DIV_W'(1);
  end

`ifdef CLK_CFG_LOSS_CNT_EN
  logic [7:0] loss_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      loss_cnt_reg <= '0;
    else if (wr_stb && (addr_reg == ADDR_LOSS_CNT))
      loss_cnt_reg <= '0;
    else if (loss_evt && (loss_cnt_reg != 8'hFF))
      loss_cnt_reg <= loss_cnt_reg + 8'd1;
  end

  assign loss_word = {24'd0, loss_cnt_reg};
`else
  assign loss_word = '0;
`endif

  assign rdata     = r_data_reg;
  assign lock_sync = sync2_reg;
  assign clk_en    = en_reg && ((div_reg <= DIV_W'(1)) || (cnt_reg == '0));

endmodule

// File: rtl/fpga_clk_cfg_ctrl.sv
// Multi-channel clock configuration controller: NUM_CH independent clk_cfg_channel instances.
// Define CLK_CFG_LOSS_CNT_EN to add a per-channel lock-loss counter at address 4.
module fpga_clk_cfg_ctrl
  import clk_cfg_pkg::*;
#(
  parameter int          NUM_CH  = 3,
  parameter int          DIV_W   = 8,
  parameter logic [31:0] ID_BASE = 32'h0001_0000
) (
  input  logic                ref_clk_i,
  input  logic                rst_glob_i,
  input  logic [NUM_CH-1:0]   cfg_req_i,
  input  logic [NUM_CH-1:0]   cfg_wrn_i,
  input  logic [NUM_CH*5-1:0] cfg_add_i,
  input  logic [NUM_CH*32-1:0] cfg_data_i,
  output logic [NUM_CH-1:0]   cfg_ack_o,
  output logic [NUM_CH*32-1:0] cfg_r_data_o,
  input  logic [NUM_CH-1:0]   lock_i,
  output logic [NUM_CH-1:0]   cfg_lock_o,
  output logic [NUM_CH-1:0]   clk_en_o
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [31:0] CH_ID = ID_BASE + (32'(gi) << 16);

    clk_cfg_channel #(
      .DIV_W   (DIV_W),
      .ID_WORD (CH_ID)
    ) u_ch (
      .clk       (ref_clk_i),
      .rst       (rst_glob_i),
      .req       (cfg_req_i[gi]),
      .wrn       (cfg_wrn_i[gi]),
      .addr      (cfg_add_i[gi*5 +: 5]),
      .wdata     (cfg_data_i[gi*32 +: 32]),
      .lock_raw  (lock_i[gi]),
      .ack       (cfg_ack_o[gi]),
      .rdata     (cfg_r_data_o[gi*32 +: 32]),
      .lock_sync (cfg_lock_o[gi]),
      .clk_en    (clk_en_o[gi])
    );
  end

endmodule
